shifter_tx: RTL
===============

// Module: shifter_tx
// PURPOSE
//  Parallel-in, serial-out transmitter. It is the sending end of the 4-bit serial
//  shifter link. It loads a WIDTH-bit word through a valid/ready handshake and
//  drives it one bit per clk1 on OUT.
//  Bit order follows the receiver's MODE convention, so a receiver in the same MODE
//  reassembles D after WIDTH qualified clk1 edges.
//  Handles back-to-back frames, end-of-frame strobe and mid-frame protection.
// PARAMETERS
//  WIDTH     4   word length in bits (>=2); bit counter is $clog2(WIDTH) bits wide
//  IDLE_OUT  0   level driven on OUT when no frame is active
// PORTS
//  clk1       in   1      single clock, all state changes on rising edge
//  Reset      in   1      asynchronous, active-low reset
//  D          in   WIDTH  parallel word to send, sampled on accepted load
//  MODE       in   1      0 = LSB first (D[0] first), 1 = MSB first (D[WIDTH-1] first)
//  LOAD       in   1      load request (valid)
//  READY      out  1      transmitter can accept LOAD this cycle
//  OUT        out  1      serial data, registered
//  OUT_VALID  out  1      OUT carries a frame bit this cycle
//  DONE       out  1      one-cycle strobe after the last bit of a frame
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE, shift reg=0, count=0, mode_q=0.
//   Outputs: READY=1, OUT=IDLE_OUT, OUT_VALID=0, DONE=0. An in-flight frame is
//   dropped with no DONE.
//  FSM states: IDLE and SHIFT. All outputs are registered; no combinational
//   input->output path except READY.
//  READY = (state==IDLE) | (state==SHIFT & count==WIDTH-1).
//  Accept = LOAD & READY at an edge. The same edge:
//   - captures D and MODE into mode_q;
//   - sets OUT to the first bit, OUT_VALID=1, count=0, state=SHIFT.
//  SHIFT, count<WIDTH-1: each edge shifts the register per mode_q, sets OUT to the
//   next bit and does count+1. Sequence is D[0]..D[W-1] (mode_q=0) or
//   D[W-1]..D[0] (mode_q=1).
//  SHIFT, count==WIDTH-1 (last bit on OUT), next edge:
//   - DONE=1 for exactly one cycle;
//   - if Accept: new frame starts with no gap, OUT_VALID stays 1;
//   - else: state=IDLE, OUT=IDLE_OUT, OUT_VALID=0.
//  Latency: first bit valid in the cycle after Accept. One frame is WIDTH cycles.
//   Sustained throughput is 1 bit/clk with back-to-back loads.
//  LOAD while READY=0 is ignored; the word is not queued. D changes mid-frame
//   have no effect.
//  MODE changes mid-frame are ignored; only mode_q is used for the frame.
//  DONE is never asserted when OUT_VALID has not been 1 for WIDTH consecutive cycles.
// TESTING
//  1 Reset=0 at any time -> READY=1, OUT=0, OUT_VALID=0, DONE=0 before next clk1 edge.
//  2 D=4'b1011, MODE=0, LOAD 1 cycle -> OUT=1,1,0,1 with OUT_VALID=1 for 4 cycles,
//    then DONE=1 one cycle. Loopback into receiver MODE=0 gives Q3..Q0=1011.
//  3 D=4'b1011, MODE=1 -> OUT=1,0,1,1; receiver MODE=1 ends with Q3..Q0=1011.
//  4 Load 1011 then LOAD 0110 in the last-bit cycle (MODE=0) -> 8 contiguous valid
//    bits 1,1,0,1,0,1,1,0. DONE pulses twice, the first with the new frame's first bit.
//  5 LOAD=1 with D=0000, and MODE toggled, at bit 2 of a 1011 frame -> frame
//    unchanged, READY=0 then, DONE exactly once.
//  6 Reset=0 during bit 2 -> immediate IDLE, no DONE. After release, a new LOAD of
//    0101 transmits correctly.

Source files
------------

// File: rtl/shifter_tx.sv
// Parallel-in, serial-out transmitter for the serial shifter link.
// Loads a WIDTH-bit word through LOAD/READY and sends it one bit per clk1 on OUT.
module shifter_tx #(
   parameter int   WIDTH    = 4,
   parameter logic IDLE_OUT = 1'b0
) (
   input  logic             clk1,
   input  logic             Reset,
   input  logic [WIDTH-1:0] D,
   input  logic             MODE,
   input  logic             LOAD,
   output logic             READY,
   output logic             OUT,
   output logic             OUT_VALID,
   output logic             DONE
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic             last_s;
   logic             ready_s;
   logic             accept_s;

   // Next-state logic: load, shift, end-of-frame and back-to-back reload.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      count_d     = count_q;
      mode_d      = mode_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;

      last_s   = (state_q == S_SHIFT) && (count_q == LAST_CNT);
      ready_s  = (state_q == S_IDLE) || last_s;
      accept_s = LOAD && ready_s;

      if (accept_s) begin
         // The first bit goes straight to OUT; the register keeps the whole word.
         state_d     = S_SHIFT;
         shreg_d     = D;
         mode_d      = MODE;
         count_d     = '0;
         out_d       = MODE ? D[WIDTH-1] : D[0];
         out_valid_d = 1'b1;
         done_d      = last_s;
      end else begin
         case (state_q)
            S_IDLE: begin
               out_d       = IDLE_OUT;
               out_valid_d = 1'b0;
            end
            S_SHIFT: begin
               if (last_s) begin
                  state_d     = S_IDLE;
                  count_d     = '0;
                  out_d       = IDLE_OUT;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else if (mode_q) begin
                  shreg_d = shreg_q << 1;
                  out_d   = shreg_q[WIDTH-2];
                  count_d = count_q + ONE_CNT;
               end else begin
                  shreg_d = shreg_q >> 1;
                  out_d   = shreg_q[1];
                  count_d = count_q + ONE_CNT;
               end
            end
            default: begin
               state_d     = S_IDLE;
               count_d     = '0;
               out_d       = IDLE_OUT;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset drops any in-flight frame silently.
   always_ff @(posedge clk1 or negedge Reset) begin
      if (!Reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         count_q     <= '0;
         mode_q      <= 1'b0;
         out_q       <= IDLE_OUT;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         count_q     <= count_d;
         mode_q      <= mode_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign READY     = ready_s;
   assign OUT       = out_q;
   assign OUT_VALID = out_valid_q;
   assign DONE      = done_q;

endmodule
